turn_signal_controller: RTL and testbench
=========================================

# turn_signal_controller

Generates the `turn_left` / `turn_right` blink signals consumed by the lamp controller. The raw turn-lever switches and the hazard push-button come from the board. Each is synchronised and debounced, then resolved by a mode state machine. The result drives a phase-aligned blinker plus a one-cycle `click` strobe for the piezo. The block sits between the switch/button pins and the lamp controller's turn inputs.

## Interface
- `BLINK_HALF_CYCLES`, default 500000: clk cycles per lamp ON or OFF half-period (1 Hz blink at 1 MHz clk); minimum 2.
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable cycles required before a debounced input changes; minimum 1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_turn_left`  in  1  raw left lever level, asynchronous.
- `sw_turn_right`  in  1  raw right lever level, asynchronous.
- `btn_hazard`  in  1  raw hazard push-button, asynchronous; each debounced press toggles hazard.
- `turn_left`  out  1  left indicator lamp, registered.
- `turn_right`  out  1  right indicator lamp, registered.
- `hazard_on`  out  1  hazard latch state, registered.
- `click`  out  1  one-cycle pulse on every edge of either lamp output.

## Operation
- **Input conditioning, per input:**
  - 2-flop synchroniser feeds the debouncer.
  - The debouncer counts cycles where the synchronised value differs from the debounced value.
  - The count clears whenever the two agree.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced value takes the synchronised value.
- **Hazard latch:** toggles on a rising edge of debounced `btn_hazard`, detected as db=1 while the previous db=0.
- **Mode FSM states:** IDLE, LEFT, RIGHT, HAZARD. Next state is computed from the next hazard value and the debounced levers, with this priority:
  1. hazard=1 → HAZARD.
  2. left only → LEFT.
  3. right only → RIGHT.
  4. both or neither → IDLE (both levers is an invalid combination).
- **Blinker:**
  - Counter runs 0..`BLINK_HALF_CYCLES`-1 and wraps; phase toggles on each wrap.
  - On any mode change, the counter clears to 0 and the phase is forced ON.
  - Consequence: the lamp lights in the first output cycle of the new mode (LEFT→RIGHT, LEFT→HAZARD, and HAZARD→LEFT all restart ON).
  - In IDLE, the counter is held at 0 with phase OFF.
- **Outputs:**
  - `turn_left` = phase AND mode ∈ {LEFT, HAZARD}.
  - `turn_right` = phase AND mode ∈ {RIGHT, HAZARD}.
  - `hazard_on` = latch.
  - `click` = 1 in the cycle either lamp output changes value, including turn-off on entry to IDLE.
- **Reset:** on the clock edge with `rst`=1:
  - Synchronisers, debounced values, counters, and the hazard latch clear to 0.
  - Mode → IDLE, phase OFF.
  - `turn_left`, `turn_right`, `hazard_on`, and `click` are all 0.
  - `rst` overrides any in-progress debounce or blink; no partial state survives.

## Timing
- Raw input change stable before edge 0 → debounced value changes at edge `DEBOUNCE_CYCLES`+1.
- Mode and `hazard_on` update at edge D+2.
- Lamp outputs and `click` update at edge D+3, where D = `DEBOUNCE_CYCLES`. End-to-end latency is exactly D+3 cycles.
- A raw glitch shorter than D consecutive synchronised cycles produces no output change.
- **Blink period:** each lamp stays high for exactly `BLINK_HALF_CYCLES` cycles and low for exactly `BLINK_HALF_CYCLES` cycles.
- **HAZARD phase alignment:** `turn_left` and `turn_right` are bit-identical every cycle.
- **Simultaneous events:**
  - A hazard press and a lever change resolving on the same edge are handled in a single transition using the priority above.
  - A mode change coinciding with a counter wrap applies the restart (phase ON) rule, not the toggle.
- Counter width is `$clog2(BLINK_HALF_CYCLES)`; the debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. Neither counter exceeds its terminal value.

## Structure
- **Shared package `car_defs`:** mode encoding localparams `TURN_IDLE`=2'd0, `TURN_LEFT`=2'd1, `TURN_RIGHT`=2'd2, `TURN_HAZARD`=2'd3. Other vehicle blocks reuse these.
- **Sub-module `input_debouncer`** (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `din`, `dout`): contains the synchroniser and the debounce counter, instantiated 3×.
- The FSM, blinker, and output registers live in the top module.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BLINK_HALF_CYCLES`=8.
- **Reset:** `rst`=1 for 2 cycles with all inputs 1 → all outputs 0 after the first edge; `hazard_on` stays 0 until a new press.
- **Left blink:** `sw_turn_left` rises before edge 0 and holds →
  - `turn_left`=1 at edges 7–14, 0 at 15–22, 1 from 23.
  - `click` pulses at edges 7, 15, 23.
  - `turn_right` stays 0.
- **Glitch:** `sw_turn_right` high for 3 cycles then low → `turn_right` and `click` never assert.
- **Hazard override:** hazard press while LEFT is mid-OFF phase →
  - Both lamps go 1 together at D+3, then blink in lockstep.
  - A second press returns to LEFT with `turn_left`=1 at its D+3 edge and `hazard_on`=0.
- **Both levers:** left held, then right also raised → IDLE; lamps 0 at D+3, with `click` only if a lamp was on.
- **Reset mid-blink:** `rst` during HAZARD ON phase → all outputs 0 next edge; after release with inputs idle, outputs stay 0.

Source files
------------

// File: rtl/car_defs.sv
// rtl/car_defs.sv - shared vehicle turn-mode encodings
// Purpose: mode encodings reused by vehicle blocks, the typed mode enum,
//          and the lever/hazard priority resolver.
// Ports:   none (package)
package car_defs;

  localparam logic [1:0] TURN_IDLE   = 2'd0;
  localparam logic [1:0] TURN_LEFT   = 2'd1;
  localparam logic [1:0] TURN_RIGHT  = 2'd2;
  localparam logic [1:0] TURN_HAZARD = 2'd3;

  typedef enum logic [1:0] {
    MODE_IDLE   = TURN_IDLE,
    MODE_LEFT   = TURN_LEFT,
    MODE_RIGHT  = TURN_RIGHT,
    MODE_HAZARD = TURN_HAZARD
  } mode_t;

  // Hazard wins; a single lever selects its side; both levers is an
  // invalid combination and falls back to idle like no lever at all.
  function automatic mode_t resolve_mode(input logic hazard,
                                         input logic left,
                                         input logic right);
    mode_t m;
    m = MODE_IDLE;
    if (hazard)              m = MODE_HAZARD;
    else if (left && !right) m = MODE_LEFT;
    else if (right && !left) m = MODE_RIGHT;
    return m;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - 2-flop synchroniser plus stability-count debouncer
// Purpose: conditions one raw asynchronous switch/button level.
// Ports:   clk  - system clock
//          rst  - synchronous active-high reset
//          din  - raw asynchronous level
//          dout - debounced level
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      count <= '0;
      dout  <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This is the edge on which the disagreement count reaches its
        // terminal value, so the output follows now and the count restarts.
        dout  <= sync[1];
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/turn_signal_controller.sv
// rtl/turn_signal_controller.sv - turn/hazard mode FSM with phase-aligned blinker
// Purpose: debounces the levers and hazard button, resolves the indicator
//          mode and drives the lamp outputs plus a click strobe.
// Ports:   clk           - system clock
//          rst           - synchronous active-high reset
//          sw_turn_left  - raw left lever level
//          sw_turn_right - raw right lever level
//          btn_hazard    - raw hazard push-button (press toggles hazard)
//          turn_left     - left lamp, registered
//          turn_right    - right lamp, registered
//          hazard_on     - hazard latch, registered
//          click         - one-cycle pulse on any lamp edge
module turn_signal_controller
  import car_defs::*;
#(
  parameter int BLINK_HALF_CYCLES = 500000,
  parameter int DEBOUNCE_CYCLES   = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_turn_left,
  input  logic sw_turn_right,
  input  logic btn_hazard,
  output logic turn_left,
  output logic turn_right,
  output logic hazard_on,
  output logic click
);

  localparam int BW = $clog2(BLINK_HALF_CYCLES);

  logic db_left;
  logic db_right;
  logic db_hazard;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk (clk),
    .rst (rst),
    .din (sw_turn_left),
    .dout(db_left)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk (clk),
    .rst (rst),
    .din (sw_turn_right),
    .dout(db_right)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
    .clk (clk),
    .rst (rst),
    .din (btn_hazard),
    .dout(db_hazard)
  );

  mode_t         mode;
  logic          phase;
  logic          btn_prev;
  logic [BW-1:0] blink_count;

  logic  hazard_next;
  mode_t mode_next;
  logic  lamp_left;
  logic  lamp_right;

  always_comb begin
    hazard_next = hazard_on ^ (db_hazard & ~btn_prev);
    // Mode follows the hazard value being latched this edge, so a press and
    // a lever change landing together resolve in a single transition.
    mode_next   = resolve_mode(hazard_next, db_left, db_right);
    lamp_left   = phase & ((mode == MODE_LEFT)  || (mode == MODE_HAZARD));
    lamp_right  = phase & ((mode == MODE_RIGHT) || (mode == MODE_HAZARD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= MODE_IDLE;
      phase       <= 1'b0;
      btn_prev    <= 1'b0;
      blink_count <= '0;
      hazard_on   <= 1'b0;
      turn_left   <= 1'b0;
      turn_right  <= 1'b0;
      click       <= 1'b0;
    end else begin
      btn_prev  <= db_hazard;
      hazard_on <= hazard_next;
      mode      <= mode_next;

      // Restart takes precedence over the wrap toggle so every new mode
      // begins with a full ON half-period.
      if (mode_next == MODE_IDLE) begin
        blink_count <= '0;
        phase       <= 1'b0;
      end else if (mode_next != mode) begin
        blink_count <= '0;
        phase       <= 1'b1;
      end else if (blink_count == BW'(BLINK_HALF_CYCLES - 1)) begin
        blink_count <= '0;
        phase       <= ~phase;
      end else begin
        blink_count <= blink_count + BW'(1);
      end

      turn_left  <= lamp_left;
      turn_right <= lamp_right;
      click      <= (lamp_left != turn_left) | (lamp_right != turn_right);
    end
  end

endmodule

// File: tb/tb_turn_signal_controller.sv
// tb/tb_turn_signal_controller.sv - scoreboard bench for turn_signal_controller
module tb_turn_signal_controller;

  logic clk;
  logic rst;
  logic sw_turn_left;
  logic sw_turn_right;
  logic btn_hazard;
  logic turn_left;
  logic turn_right;
  logic hazard_on;
  logic click;

  turn_signal_controller #(
    .BLINK_HALF_CYCLES(8),
    .DEBOUNCE_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_turn_left (sw_turn_left),
    .sw_turn_right(sw_turn_right),
    .btn_hazard   (btn_hazard),
    .turn_left    (turn_left),
    .turn_right   (turn_right),
    .hazard_on    (hazard_on),
    .click        (click)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic tl;
    logic tr;
    logic hz;
    logic ck;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  logic mon_en  = 1'b0;
  logic prev_hz = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    else n_pass++;
  endfunction

  function automatic void expect_ev(input int at, input logic tl, input logic tr,
                                    input logic hz, input logic ck);
    ev_t e;
    e.at = at; e.tl = tl; e.tr = tr; e.hz = hz; e.ck = ck;
    exp_q.push_back(e);
  endfunction

  // Monitor: any click or hazard_on change is a DUT output event that must
  // match the head of the expected-event queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (click === 1'b1 || hazard_on !== prev_hz) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {28'd0, turn_left, turn_right, hazard_on, click}, 32'hFFFF_FFFF);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk($sformatf("event_cycle@%0d", e.at), cyc, e.at);
          chk($sformatf("turn_left@%0d", e.at), turn_left, e.tl);
          chk($sformatf("turn_right@%0d", e.at), turn_right, e.tr);
          chk($sformatf("hazard_on@%0d", e.at), hazard_on, e.hz);
          chk($sformatf("click@%0d", e.at), click, e.ck);
        end
      end
      if (hazard_on === 1'b1) chk("hazard_lockstep", turn_left, turn_right);
      prev_hz = hazard_on;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int b;
    int g;

    // Reset with every input high
    rst = 1'b1; sw_turn_left = 1'b1; sw_turn_right = 1'b1; btn_hazard = 1'b1;
    @(negedge clk);
    chk("reset_turn_left",  turn_left,  1'b0);
    chk("reset_turn_right", turn_right, 1'b0);
    chk("reset_hazard_on",  hazard_on,  1'b0);
    chk("reset_click",      click,      1'b0);
    @(negedge clk);
    rst = 1'b0; sw_turn_left = 1'b0; sw_turn_right = 1'b0; btn_hazard = 1'b0;
    prev_hz = 1'b0;
    mon_en  = 1'b1;
    wait_until(cyc + 20);
    chk("post_reset_hazard_on", hazard_on, 1'b0);

    // Glitch of 3 cycles on the right lever: no event expected
    g = cyc;
    sw_turn_right = 1'b1;
    wait_until(g + 3);
    sw_turn_right = 1'b0;
    wait_until(g + 23);
    chk("glitch_turn_right", turn_right, 1'b0);

    // Left blink; b is edge 0 of the lever change
    b = cyc + 1;
    sw_turn_left = 1'b1;
    expect_ev(b + 7,  1, 0, 0, 1);
    expect_ev(b + 15, 0, 0, 0, 1);
    expect_ev(b + 23, 1, 0, 0, 1);
    expect_ev(b + 31, 0, 0, 0, 1);

    // Hazard press mid-OFF; mode change lands on the LEFT wrap edge
    wait_until(b + 31);
    btn_hazard = 1'b1;
    expect_ev(b + 38, 0, 0, 1, 0);
    expect_ev(b + 39, 1, 1, 1, 1);
    expect_ev(b + 47, 0, 0, 1, 1);
    expect_ev(b + 55, 1, 1, 1, 1);
    wait_until(b + 39);
    btn_hazard = 1'b0;

    // Second press returns to LEFT
    wait_until(b + 57);
    btn_hazard = 1'b1;
    expect_ev(b + 63, 0, 0, 1, 1);
    expect_ev(b + 64, 0, 0, 0, 0);
    expect_ev(b + 65, 1, 0, 0, 1);

    // Right lever joins while left held -> IDLE, lamp was on so it clicks
    wait_until(b + 62);
    sw_turn_right = 1'b1;
    expect_ev(b + 70, 0, 0, 0, 1);
    wait_until(b + 65);
    btn_hazard = 1'b0;
    wait_until(b + 75);
    chk("both_levers_left",  turn_left,  1'b0);
    chk("both_levers_right", turn_right, 1'b0);

    // Release levers, enter hazard from IDLE, then reset during ON phase
    wait_until(b + 80);
    sw_turn_left = 1'b0; sw_turn_right = 1'b0;
    wait_until(b + 90);
    btn_hazard = 1'b1;
    expect_ev(b + 97, 0, 0, 1, 0);
    expect_ev(b + 98, 1, 1, 1, 1);
    wait_until(b + 98);
    btn_hazard = 1'b0;
    wait_until(b + 100);
    rst = 1'b1;
    expect_ev(b + 101, 0, 0, 0, 0);
    wait_until(b + 101);
    chk("midblink_reset_left",  turn_left,  1'b0);
    chk("midblink_reset_right", turn_right, 1'b0);
    chk("midblink_reset_click", click,      1'b0);
    wait_until(b + 102);
    rst = 1'b0;
    wait_until(b + 132);
    chk("idle_after_reset_left",   turn_left,  1'b0);
    chk("idle_after_reset_hazard", hazard_on,  1'b0);
    chk("events_outstanding", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
